// File: rtl/mux_arb_nx1_pkg.sv
// Shared definitions for the N:1 registered handshake multiplexer.
// Holds the runtime mode encoding and the default channel width.
package mux_arb_nx1_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_arb_nx1_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping from N-1 back to 0.
module rr_arbiter_nx1 #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Upper segment [ptr, N-1] has priority over the wrapped segment [0, ptr-1].
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && (i >= 32'(ptr)) && req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = SW'(i);
        any       = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && (i < 32'(ptr)) && req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = SW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-input registered multiplexer with valid/ready on every channel, a one-entry
// output register, and explicit-select or round-robin source choice.
module mux_arb_nx1
  import mux_arb_nx1_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned N     = 4,
  parameter int unsigned SW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  mode_e            mode_w;
  logic [N-1:0]     sel_grant;
  logic [N-1:0]     rr_grant;
  logic [SW-1:0]    rr_idx;
  logic             rr_any;
  logic [N-1:0]     grant;
  logic [SW-1:0]    grant_idx;
  logic             has_grant;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    src_q, src_d;
  logic             valid_q, valid_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;

  assign mode_w = mode_e'(mode);

  rr_arbiter_nx1 #(
    .N  (N),
    .SW (SW)
  ) u_rr (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  // Out-of-range sel matches no channel, so it never grants.
  always_comb begin
    sel_grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_grant[i] = (32'(sel) == i) && in_valid[i];
    end
  end

  always_comb begin
    if (mode_w == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
      has_grant = rr_any;
    end else begin
      grant     = sel_grant;
      grant_idx = sel;
      has_grant = |sel_grant;
    end
  end

  // rst_n gates acceptance so no channel sees a handshake while held in reset.
  assign can_accept = rst_n && (!valid_q || out_ready);
  assign in_ready   = can_accept ? grant : '0;
  assign xfer       = can_accept && has_grant;

  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    data_d   = data_q;
    src_d    = src_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      data_d  = mux_data;
      src_d   = grant_idx;
      valid_d = 1'b1;
      if (mode_w == MODE_RR) begin
        rr_ptr_d = (32'(rr_idx) == N - 1) ? '0 : rr_idx + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      src_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      src_q    <= src_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1: the driver pushes hand-computed words into a
// scoreboard queue and a monitor pops/compares whenever the output is consumed.
module tb_mux_arb_nx1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic         mode;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [1:0]   sel3;
  logic         mode3;
  logic [31:0]  out_data3;
  logic [1:0]   out_src3;
  logic         out_valid3;
  logic         out_ready3;

  logic [31:0]  chdat [4];
  logic [33:0]  exp_q [$];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  mux_arb_nx1 #(.WIDTH(32), .N(4), .SW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_arb_nx1 #(.WIDTH(32), .N(3), .SW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [3:0] v, input logic [1:0] s, input logic m,
                     input logic ordy, input logic [3:0] exp_rdy,
                     input logic [1:0] exp_src, input logic exp_ov, input string tag);
    in_valid  = v;
    sel       = s;
    mode      = m;
    out_ready = ordy;
    @(negedge clk);
    chk({tag, " in_ready"}, 34'(in_ready), 34'(exp_rdy));
    chk({tag, " out_valid"}, 34'(out_valid), 34'(exp_ov));
    chk({tag, " n3 in_ready"}, 34'(in_ready3), 34'(3'b000));
    chk({tag, " n3 out_valid"}, 34'(out_valid3), 34'(1'b0));
    if (exp_rdy != 4'b0000) exp_q.push_back({exp_src, chdat[exp_src]});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed output word must match the oldest expected entry.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected pop", {out_src, out_data}, 34'h0);
          if ({out_src, out_data} == 34'h0) begin
            errors++;
            $display("FAIL unexpected pop: got empty word expected no output at %0t", $time);
          end
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard word", {out_src, out_data}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    chdat[0] = 32'hA000_0000;
    chdat[1] = 32'hB111_1111;
    chdat[2] = 32'hDEAD_BEEF;
    chdat[3] = 32'hC333_3333;
    in_data  = {chdat[3], chdat[2], chdat[1], chdat[0]};
    in_data3   = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    in_valid3  = 3'b111;
    sel3       = 2'd3;
    mode3      = 1'b0;
    out_ready3 = 1'b1;

    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    sel       = 2'd0;
    mode      = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset out_valid", 34'(out_valid), 34'(1'b0));
    chk("reset out_data", 34'(out_data), 34'h0);
    chk("reset in_ready", 34'(in_ready), 34'(4'b0000));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Explicit select, then an unsatisfied select
    cyc(4'b0110, 2'd2, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0, "m0 sel2");
    cyc(4'b0110, 2'd3, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, "m0 sel3 novalid");
    cyc(4'b0000, 2'd3, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, "m0 drained");

    // Round-robin fairness over all-valid inputs
    cyc(4'b1111, 2'd0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, "rr all g0");
    cyc(4'b1111, 2'd0, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, "rr all g1");
    cyc(4'b1111, 2'd0, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, "rr all g2");
    cyc(4'b1111, 2'd0, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, "rr all g3");
    cyc(4'b1111, 2'd0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, "rr all g0 again");
    // ptr=1, only ch3/ch0 requesting: 3 then wrap to 0
    cyc(4'b1001, 2'd0, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, "rr 1001 g3");
    cyc(4'b1001, 2'd0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, "rr 1001 wrap g0");

    // Backpressure: held word (ch0) must stay put
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0010, 2'd0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, "stall");
      chk("stall out_data", 34'(out_data), 34'(chdat[0]));
      chk("stall out_src", 34'(out_src), 34'(2'd0));
    end
    cyc(4'b0010, 2'd0, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, "pop+xfer g1");
    chk("pop+xfer out_valid", 34'(out_valid), 34'(1'b1));
    chk("pop+xfer out_src", 34'(out_src), 34'(2'd1));

    // Mode switch: rr ptr=2 here; ch0,ch1 in mode 1, two mode-0 words, back to rr
    cyc(4'b0011, 2'd0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, "switch rr g0");
    cyc(4'b0011, 2'd0, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, "switch rr g1");
    cyc(4'b1111, 2'd0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, "switch m0 a");
    cyc(4'b1111, 2'd0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, "switch m0 b");
    cyc(4'b1111, 2'd0, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, "switch rr g2");
    cyc(4'b0000, 2'd0, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b1, "drain pop");
    cyc(4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, "idle");

    // Reset while a word is held: it is dropped, not replayed
    cyc(4'b0010, 2'd1, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, "pre-reset load");
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("async reset out_valid", 34'(out_valid), 34'(1'b0));
    chk("async reset out_data", 34'(out_data), 34'h0);
    chk("async reset out_src", 34'(out_src), 34'(2'd0));
    chk("async reset in_ready", 34'(in_ready), 34'(4'b0000));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b0010, 2'd1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, "post-reset xfer");
    cyc(4'b0000, 2'd1, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, "post-reset pop");
    cyc(4'b0000, 2'd1, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, "post-reset idle");

    @(negedge clk);
    chk("scoreboard empty", 34'(exp_q.size()), 34'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
